icache_ctrl: RTL and testbench
==============================

ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 32: number of direct-mapped lines, power of two.
REQ-002 SHALL have parameter WORDS_PER_LINE, default 8: 16-bit words per line, power of two.
REQ-003 SHALL have ports: clk input 1 (rising-edge clock); rst input 1 (asynchronous, active-high reset).
REQ-004 SHALL have ports: if_addr input 16 (byte address from fetch stage PC); if_rd_en input 1 (fetch request valid).
REQ-005 SHALL have ports: if_instr output 16 (instruction word); if_stall output 1 (instruction not yet available).
REQ-006 SHALL have ports: mem_req output 1 (line fill request pulse); mem_addr output 16 (line-aligned byte address).
REQ-007 SHALL have ports: mem_rdata input 16 (fill word); mem_rvalid input 1 (fill word valid, words delivered in ascending order).

Function
REQ-008 SHALL split the address into offset if_addr[3:1], index if_addr[8:4] and tag if_addr[15:9] at default parameters; if_addr[0] is ignored.
REQ-009 SHALL detect a hit when if_rd_en=1, the indexed line is valid and the stored tag equals the address tag.
REQ-010 SHALL drive if_instr from a combinational data-array read and if_stall=0 in the same cycle as a hit (zero-cycle hit latency).
REQ-011 SHALL keep if_stall=0 and if_instr=16'h0000 when if_rd_en=0.
REQ-012 SHALL implement FSM states IDLE, REQ, FILL, DONE.
REQ-013 SHALL go IDLE->REQ on a miss, latching the miss index and tag; if_stall=1 from the miss cycle onward.
REQ-014 SHALL assert mem_req for exactly one cycle in REQ, with mem_addr = {tag, index, 4'b0000}, then go to FILL.
REQ-015 SHALL in FILL write each mem_rvalid word to the latched index at a 3-bit word counter, incrementing it, and ignore mem_rvalid in every other state.
REQ-016 SHALL go FILL->DONE when the counter wraps 7->0, then set the line valid bit and store the tag in DONE.
REQ-017 SHALL go DONE->IDLE unconditionally; the retried lookup hits in the following IDLE cycle, so miss-to-data latency is (memory latency + 8 + 2) cycles.
REQ-018 SHALL keep if_stall=1 in REQ, FILL and DONE regardless of if_addr changes.
REQ-019 SHALL complete a started fill even if if_addr changes mid-fill (branch redirect); the new address is looked up after DONE.
REQ-020 SHALL clear the line valid bit when the first FILL word is written, so a partially filled line never hits.
REQ-021 SHALL hold mem_addr stable from REQ through DONE; mem_req=0 outside REQ.

Reset
REQ-022 SHALL on rst clear all valid bits, set the FSM to IDLE, counter to 0, mem_req=0, mem_addr=0, if_stall=0 and if_instr=0.
REQ-023 SHALL abort an in-progress fill on rst; the partial line remains invalid and late mem_rvalid words are ignored.
REQ-024 SHALL not reset the tag or data arrays.

Configuration
REQ-025 SHALL, with ICACHE_PERF_EN defined, add outputs perf_hits output 32 and perf_misses output 32, counting hit cycles and IDLE->REQ transitions, saturating at 32'hFFFFFFFF and cleared by rst.
REQ-026 SHALL, without ICACHE_PERF_EN, have neither perf port nor counter logic.

Structure
REQ-027 SHALL place the state encoding, field widths and offset/index/tag bit positions in the shared package icache_pkg.
REQ-028 SHALL instantiate one sub-module icache_data_array (LINES x WORDS_PER_LINE x 16, one synchronous write port, one asynchronous read port).

Verification
REQ-029 SHALL cover cold miss: after rst, if_rd_en=1, if_addr=16'h0000 -> if_stall=1, one mem_req with mem_addr=16'h0000, 8 words 16'hA000..16'hA007 delivered, if_instr=16'hA000 with if_stall=0 two cycles after the last word.
REQ-030 SHALL cover hit: then if_addr=16'h000E -> if_instr=16'hA007, if_stall=0 same cycle, no mem_req.
REQ-031 SHALL cover conflict: if_addr=16'h0200 (same index, tag 1) -> miss, mem_addr=16'h0200; afterwards 16'h0000 misses again.
REQ-032 SHALL cover redirect mid-fill: if_addr changed to 16'h0040 during FILL -> fill of the original line completes, then second mem_req with mem_addr=16'h0040.
REQ-033 SHALL cover reset mid-fill: rst after 3 words -> if_stall=0, FSM IDLE, the same address misses again with a new mem_req.
REQ-034 SHALL cover ICACHE_PERF_EN: scenarios 1-2 -> perf_misses=1, perf_hits>=2.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache controller:
// FSM encoding, address field layout and word widths.
package icache_pkg;

  localparam int unsigned AddrW = 16;
  localparam int unsigned WordW = 16;

  // Default geometry: 32 lines x 8 halfwords.
  localparam int unsigned DefLines        = 32;
  localparam int unsigned DefWordsPerLine = 8;
  localparam int unsigned DefOffsetW      = 3;
  localparam int unsigned DefIndexW       = 5;
  localparam int unsigned DefTagW         = 7;

  // Byte bit 0 is dropped; the offset selects a 16-bit word.
  localparam int unsigned OffsetLsb    = 1;
  localparam int unsigned DefIndexLsb  = OffsetLsb + DefOffsetW;
  localparam int unsigned DefTagLsb    = DefIndexLsb + DefIndexW;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StFill = 2'd2,
    StDone = 2'd3
  } icache_state_e;

  function automatic int unsigned index_lsb(input int unsigned off_w);
    return OffsetLsb + off_w;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned off_w, input int unsigned idx_w);
    return OffsetLsb + off_w + idx_w;
  endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The cache uses the slave modport; the fetch stage / memory model use master.
interface icache_ctrl_if;
  logic [15:0] if_addr;
  logic        if_rd_en;
  logic [15:0] if_instr;
  logic        if_stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  modport master (
    output if_addr, if_rd_en, mem_rdata, mem_rvalid,
    input  if_instr, if_stall, mem_req, mem_addr
  );

  modport slave (
    input  if_addr, if_rd_en, mem_rdata, mem_rvalid,
    output if_instr, if_stall, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_data_array.sv
// Cache data storage: LINES x WORDS_PER_LINE halfwords, one synchronous
// write port and one asynchronous (combinational) read port. Not reset.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int unsigned LINES          = DefLines,
  parameter int unsigned WORDS_PER_LINE = DefWordsPerLine
) (
  input  logic                              clk_i,
  input  logic                              we_i,
  input  logic [$clog2(LINES)-1:0]          widx_i,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] woff_i,
  input  logic [WordW-1:0]                  wdata_i,
  input  logic [$clog2(LINES)-1:0]          ridx_i,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] roff_i,
  output logic [WordW-1:0]                  rdata_o
);

  localparam int unsigned Depth = LINES * WORDS_PER_LINE;

  logic [WordW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[{widx_i, woff_i}] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[{ridx_i, roff_i}];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with zero-cycle hits and a
// blocking line refill. Optional counters enabled by defining ICACHE_PERF_EN.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned LINES          = DefLines,
  parameter int unsigned WORDS_PER_LINE = DefWordsPerLine
) (
  input  logic               clk,
  input  logic               rst,
  icache_ctrl_if.slave       bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]        perf_hits,
  output logic [31:0]        perf_misses
`endif
);

  localparam int unsigned OffW   = $clog2(WORDS_PER_LINE);
  localparam int unsigned IdxW   = $clog2(LINES);
  localparam int unsigned IdxLsb = index_lsb(OffW);
  localparam int unsigned TagLsb = tag_lsb(OffW, IdxW);
  localparam int unsigned TagW   = AddrW - TagLsb;

  logic [OffW-1:0] req_off;
  logic [IdxW-1:0] req_idx;
  logic [TagW-1:0] req_tag;

  assign req_off = bus.if_addr[OffsetLsb +: OffW];
  assign req_idx = bus.if_addr[IdxLsb +: IdxW];
  assign req_tag = bus.if_addr[TagLsb +: TagW];

  icache_state_e   state_q, state_d;
  logic [OffW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] miss_idx_q, miss_idx_d;
  logic [TagW-1:0] miss_tag_q, miss_tag_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TagW-1:0] tag_q [LINES];

  logic             lookup_hit;
  logic             idle_hit;
  logic             idle_miss;
  logic             fill_we;
  logic             tag_we;
  logic             mem_req;
  logic             if_stall;
  logic [WordW-1:0] if_instr;
  logic [WordW-1:0] rd_word;

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign idle_hit   = !rst && (state_q == StIdle) && bus.if_rd_en && lookup_hit;
  assign idle_miss  = !rst && (state_q == StIdle) && bus.if_rd_en && !lookup_hit;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (idle_miss) state_d = StReq;
      StReq:  state_d = StFill;
      StFill: if (bus.mem_rvalid && (cnt_q == OffW'(WORDS_PER_LINE - 1))) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; reset forces the fetch side quiet even while rd_en is high.
  always_comb begin
    mem_req  = 1'b0;
    if_stall = 1'b0;
    if_instr = '0;
    fill_we  = 1'b0;
    tag_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.if_rd_en) begin
          if (lookup_hit) if_instr = rd_word;
          else            if_stall = 1'b1;
        end
      end
      StReq: begin
        mem_req  = 1'b1;
        if_stall = 1'b1;
      end
      StFill: begin
        if_stall = 1'b1;
        fill_we  = bus.mem_rvalid;
      end
      StDone: begin
        if_stall = 1'b1;
        tag_we   = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      mem_req  = 1'b0;
      if_stall = 1'b0;
      if_instr = '0;
      fill_we  = 1'b0;
      tag_we   = 1'b0;
    end
  end

  // Miss bookkeeping, fill counter and valid bits.
  always_comb begin
    cnt_d      = cnt_q;
    miss_idx_d = miss_idx_q;
    miss_tag_d = miss_tag_q;
    valid_d    = valid_q;
    if (idle_miss) begin
      miss_idx_d = req_idx;
      miss_tag_d = req_tag;
    end
    if (fill_we) begin
      cnt_d = cnt_q + OffW'(1);
      // Invalidate on the first word so a partially refilled line never hits.
      if (cnt_q == '0) valid_d[miss_idx_q] = 1'b0;
    end
    if (tag_we) valid_d[miss_idx_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      valid_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_q[miss_idx_q] <= miss_tag_q;
  end

  icache_data_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_data (
    .clk_i   (clk),
    .we_i    (fill_we),
    .widx_i  (miss_idx_q),
    .woff_i  (cnt_q),
    .wdata_i (bus.mem_rdata),
    .ridx_i  (req_idx),
    .roff_i  (req_off),
    .rdata_o (rd_word)
  );

  assign bus.if_instr = if_instr;
  assign bus.if_stall = if_stall;
  assign bus.mem_req  = mem_req;
  // Derived from the latched miss fields, so it holds from REQ through DONE.
  assign bus.mem_addr = {miss_tag_q, miss_idx_q, {IdxLsb{1'b0}}};

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hits_q, perf_hits_d;
  logic [31:0] perf_misses_q, perf_misses_d;

  always_comb begin
    perf_hits_d   = perf_hits_q;
    perf_misses_d = perf_misses_q;
    if (idle_hit && (perf_hits_q != 32'hFFFF_FFFF))    perf_hits_d   = perf_hits_q + 32'd1;
    if (idle_miss && (perf_misses_q != 32'hFFFF_FFFF)) perf_misses_d = perf_misses_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hits_q   <= '0;
      perf_misses_q <= '0;
    end else begin
      perf_hits_q   <= perf_hits_d;
      perf_misses_q <= perf_misses_d;
    end
  end

  assign perf_hits   = perf_hits_q;
  assign perf_misses = perf_misses_q;
`else
  logic unused_hit;
  assign unused_hit = idle_hit;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: expected instructions and refill
// addresses are queued as fetches are issued and popped as the DUT answers.
module tb_icache_ctrl;

  localparam int unsigned MemLat = 3;
  localparam int unsigned Words  = 8;
  localparam int          Bound  = 100;

  logic clk = 1'b0;
  logic rst;

  icache_ctrl_if bus ();

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;
`endif

  icache_ctrl #(
    .LINES          (32),
    .WORDS_PER_LINE (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef ICACHE_PERF_EN
    .perf_hits   (perf_hits),
    .perf_misses (perf_misses),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int last_word_cyc = 0;
  int words_sent    = 0;
  bit resp_busy     = 1'b0;

  logic [15:0] exp_instr_q [$];
  logic [15:0] exp_req_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory image: word i of the line at byte address L is (A000 + i) ^ L.
  function automatic logic [15:0] exp_word(input logic [15:0] a);
    logic [15:0] line;
    line = {a[15:4], 4'h0};
    return (16'hA000 + {13'd0, a[3:1]}) ^ line;
  endfunction

  // Output monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req) begin
        check_val("mem_req_expected", 32'(exp_req_q.size() != 0), 32'd1);
        if (exp_req_q.size() != 0) check_val("mem_addr", 32'(bus.mem_addr), 32'(exp_req_q.pop_front()));
      end
      if (bus.if_rd_en && !bus.if_stall) begin
        check_val("instr_expected", 32'(exp_instr_q.size() != 0), 32'd1);
        if (exp_instr_q.size() != 0) check_val("if_instr", 32'(bus.if_instr), 32'(exp_instr_q.pop_front()));
      end
      if (!bus.if_rd_en) check_val("idle_out", {15'd0, bus.if_stall, bus.if_instr}, 32'd0);
    end
  end

  // Memory responder: fixed latency, then eight ascending words.
  initial begin : resp
    logic [15:0] line;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !rst) begin
        line       = bus.mem_addr;
        words_sent = 0;
        resp_busy  = 1'b1;
        repeat (MemLat) @(posedge clk);
        for (int i = 0; i < Words; i++) begin
          #1;
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = (16'hA000 + 16'(i)) ^ line;
          last_word_cyc  = cyc;
          @(posedge clk);
          words_sent = i + 1;
        end
        #1;
        bus.mem_rvalid = 1'b0;
        resp_busy      = 1'b0;
      end
    end
  end

  task automatic do_fetch(input logic [15:0] a, input bit miss, output int hit_cyc);
    int n;
    @(posedge clk);
    #1;
    bus.if_addr  = a;
    bus.if_rd_en = 1'b1;
    exp_instr_q.push_back(exp_word(a));
    if (miss) exp_req_q.push_back({a[15:4], 4'h0});
    @(negedge clk);
    check_val("stall_first", 32'(bus.if_stall), 32'(miss));
    n = 0;
    while (bus.if_stall && n < Bound) begin
      @(negedge clk);
      n++;
    end
    if (bus.if_stall) check_val("fetch_timeout", 32'(bus.if_stall), 32'd0);
    hit_cyc = cyc;
    @(posedge clk);
    #1;
    bus.if_rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int hc;
    int n;
    rst          = 1'b1;
    bus.if_addr  = '0;
    bus.if_rd_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_stall", 32'(bus.if_stall), 32'd0);
    check_val("rst_instr", 32'(bus.if_instr), 32'd0);
    check_val("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_val("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    bus.if_rd_en = 1'b1;
    #1;
    check_val("rst_stall_rd", 32'(bus.if_stall), 32'd0);
    bus.if_rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold miss, then same-line hit
    do_fetch(16'h0000, 1'b1, hc);
    check_val("cold_latency", 32'(hc - last_word_cyc), 32'd2);
    do_fetch(16'h000E, 1'b0, hc);
`ifdef ICACHE_PERF_EN
    check_val("perf_misses", perf_misses, 32'd1);
    check_val("perf_hits_ge2", 32'(perf_hits >= 32'd2), 32'd1);
`endif

    // Conflict on index 0
    do_fetch(16'h0200, 1'b1, hc);
    do_fetch(16'h0000, 1'b1, hc);
    do_fetch(16'h0006, 1'b0, hc);

    // Redirect during fill
    @(posedge clk);
    #1;
    bus.if_addr  = 16'h0030;
    bus.if_rd_en = 1'b1;
    exp_req_q.push_back(16'h0030);
    n = 0;
    while (!(resp_busy && words_sent >= 2) && n < Bound) begin
      @(negedge clk);
      n++;
    end
    check_val("redir_fill_started", 32'(resp_busy && words_sent >= 2), 32'd1);
    check_val("redir_fill_stall", 32'(bus.if_stall), 32'd1);
    @(posedge clk);
    #1;
    bus.if_addr = 16'h0040;
    exp_instr_q.push_back(exp_word(16'h0040));
    exp_req_q.push_back(16'h0040);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.if_stall && n < Bound);
    check_val("redir_done", 32'(bus.if_stall), 32'd0);
    @(posedge clk);
    #1;
    bus.if_rd_en = 1'b0;
    do_fetch(16'h0030, 1'b0, hc);
    do_fetch(16'h0046, 1'b0, hc);

    // Reset in the middle of a refill
    @(posedge clk);
    #1;
    bus.if_addr  = 16'h0400;
    bus.if_rd_en = 1'b1;
    exp_req_q.push_back(16'h0400);
    n = 0;
    while (!(resp_busy && words_sent >= 3) && n < Bound) begin
      @(negedge clk);
      n++;
    end
    check_val("rstfill_started", 32'(resp_busy && words_sent >= 3), 32'd1);
    rst = 1'b1;
    #1;
    check_val("rstfill_stall", 32'(bus.if_stall), 32'd0);
    check_val("rstfill_mem_req", 32'(bus.mem_req), 32'd0);
    check_val("rstfill_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_val("rstfill_instr", 32'(bus.if_instr), 32'd0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.if_rd_en = 1'b0;
    n = 0;
    while (resp_busy && n < Bound) begin
      @(negedge clk);
      n++;
    end
    check_val("late_words_done", 32'(resp_busy), 32'd0);
    do_fetch(16'h0400, 1'b1, hc);
    do_fetch(16'h0000, 1'b1, hc);

    repeat (3) @(posedge clk);
    check_val("sb_instr_left", 32'(exp_instr_q.size()), 32'd0);
    check_val("sb_req_left", 32'(exp_req_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
